// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned multiplier consuming K bits of b per cycle.
// Optional MUL_EARLY_TERM_EN stops once the remaining upper bits of b are all zero.
`default_nettype none

module shift_add_multiplier #(
  parameter int A_W = 16,
  parameter int B_W = 16,
  parameter int K   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [A_W+B_W-1:0] c
);

  localparam int N     = (B_W + K - 1) / K;
  localparam int P_W   = A_W + B_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [P_W-1:0]   acc;
  logic [P_W-1:0]   a_sh;
  logic [B_W-1:0]   b_sh;
  logic [CNT_W-1:0] cnt;
  logic [P_W-1:0]   partial;
  logic             last;

  // a is pre-shifted and b consumed from the bottom, so each chunk sits at bit 0
  assign partial = a_sh * P_W'(b_sh[K-1:0]);

`ifdef MUL_EARLY_TERM_EN
  assign last = (cnt == CNT_W'(N - 1)) || ((b_sh >> K) == '0);
`else
  assign last = (cnt == CNT_W'(N - 1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_vld) begin
            a_sh  <= P_W'(a);
            b_sh  <= b;
            acc   <= '0;
            cnt   <= '0;
            state <= (a == '0 || b == '0) ? DONE : CALC;
          end
        end
        CALC: begin
          acc  <= acc + partial;
          a_sh <= a_sh << K;
          b_sh <= b_sh >> K;
          cnt  <= cnt + 1'b1;
          if (last) state <= DONE;
        end
        DONE: begin
          if (out_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_rdy  = (state == IDLE);
  assign out_vld = (state == DONE);
  assign c       = (state == DONE) ? acc : '0;

endmodule

`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
// Directed and randomized back-to-back checks for shift_add_multiplier (A_W=B_W=16, K=2).
`default_nettype none

module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld;
  logic        in_rdy;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_vld;
  logic        out_rdy;
  logic [31:0] c;

  int n_total = 0;
  int n_bad   = 0;

  shift_add_multiplier #(.A_W(16), .B_W(16), .K(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .a       (a),
    .b       (b),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .c       (c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand pair with out_rdy=1 and check latency and product.
  task automatic do_mul(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input int exp_lat, input logic [31:0] exp_c);
    int lat;
    int w;
    w = 0;
    while (!in_rdy && w < 50) begin tick(); w++; end
    out_rdy = 1'b1;
    a = av; b = bv; in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    a = 16'hdead; b = 16'hbeef;
    lat = 1;
    while (!out_vld && lat < 50) begin tick(); lat++; end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_c"}, 64'(c), 64'(exp_c));
    tick();
    chk({tag, "_idle"}, 64'(in_rdy), 64'd1);
  endtask

  logic [31:0] exp_q[$];
  int          n_acc;
  int          n_out;
  int          cyc;
  logic        acc_now;
  logic        out_now;
  int          lat_basic;

  initial begin
`ifdef MUL_EARLY_TERM_EN
    lat_basic = 3;
`else
    lat_basic = 9;
`endif
    rst = 1'b1; in_vld = 1'b0; a = '0; b = '0; out_rdy = 1'b0;
    #1;
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);
    chk("rst_out_vld", 64'(out_vld), 64'd0);
    chk("rst_c", 64'(c), 64'd0);
    tick(); tick();
    rst = 1'b0;

    do_mul("basic", 16'd3, 16'd5, lat_basic, 32'd15);
    do_mul("max", 16'hffff, 16'hffff, 9, 32'hfffe0001);
    do_mul("zskip_b", 16'h1234, 16'h0000, 1, 32'd0);
    do_mul("zskip_a", 16'h0000, 16'hffff, 1, 32'd0);
    do_mul("hibit", 16'h8000, 16'h8000, 9, 32'h40000000);

    // backpressure
    out_rdy = 1'b0;
    a = 16'd7; b = 16'd9; in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    cyc = 0;
    while (!out_vld && cyc < 50) begin tick(); cyc++; end
    chk("bp_seen", 64'(out_vld), 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_c", 64'(c), 64'd63);
      chk("bp_in_rdy", 64'(in_rdy), 64'd0);
      chk("bp_out_vld", 64'(out_vld), 64'd1);
      tick();
    end
    chk("bp_c_hold", 64'(c), 64'd63);
    out_rdy = 1'b1;
    tick();
    chk("bp_release_in_rdy", 64'(in_rdy), 64'd1);
    chk("bp_release_out_vld", 64'(out_vld), 64'd0);

    // reset mid-operation
    a = 16'hffff; b = 16'h8001; in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_in_rdy", 64'(in_rdy), 64'd1);
    chk("mid_rst_c", 64'(c), 64'd0);
    chk("mid_rst_out_vld", 64'(out_vld), 64'd0);
    tick();
    rst = 1'b0;
    out_now = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_vld) out_now = 1'b1;
      tick();
    end
    chk("mid_rst_no_out", 64'(out_now), 64'd0);
    do_mul("after_rst", 16'd2, 16'd3, lat_basic, 32'd6);

    // back-to-back random traffic
    n_acc = 0; n_out = 0; cyc = 0;
    a = 16'($urandom); b = 16'($urandom); in_vld = 1'b1;
    while ((n_acc < 100 || n_out < 100) && cyc < 20000) begin
      out_rdy = 1'($urandom_range(0, 1));
      in_vld  = (n_acc < 100);
      @(negedge clk);
      acc_now = in_vld && in_rdy;
      out_now = out_vld && out_rdy;
      if (acc_now) exp_q.push_back(32'(a) * 32'(b));
      if (out_now) begin
        if (exp_q.size() == 0) chk("b2b_extra", 64'd1, 64'd0);
        else chk("b2b_c", 64'(c), 64'(exp_q.pop_front()));
        n_out++;
      end
      tick();
      cyc++;
      if (acc_now) begin
        n_acc++;
        a = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom);
        b = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom);
      end
    end
    chk("b2b_out_count", 64'(n_out), 64'd100);
    chk("b2b_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
